// File: rtl/sfx_arbiter_if.sv
// Bundle between game logic / sound-effect players and the arbiter:
// play requests, start pulses, grant status and the per-player Pmod lines.
interface sfx_arbiter_if #(
    parameter int N_SRC = 4
);
    localparam int ID_W = $clog2(N_SRC);

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] p1_in;
    logic [N_SRC-1:0] p2_in;
    logic [N_SRC-1:0] p4_in;
    logic [N_SRC-1:0] play;
    logic             busy;
    logic [ID_W-1:0]  cur_id;
    logic             pmod_1;
    logic             pmod_2;
    logic             pmod_4;

    modport master (
        output req, p1_in, p2_in, p4_in,
        input  play, busy, cur_id, pmod_1, pmod_2, pmod_4
    );

    modport slave (
        input  req, p1_in, p2_in, p4_in,
        output play, busy, cur_id, pmod_1, pmod_2, pmod_4
    );
endinterface

// File: rtl/sfx_arbiter.sv
// Fixed-priority, pre-emptive arbiter sharing one Pmod audio output among
// N_SRC sound-effect players, with a request queue and a muted gap between clips.
module sfx_arbiter #(
    parameter int N_SRC      = 4,
    parameter int SFX_CYCLES = 100_000_000,
    parameter int GAP_CYCLES = 1_000_000,
    parameter int CNT_W      = 27
) (
    input  logic            clk,
    input  logic            rst,
    sfx_arbiter_if.slave    bus
);
    localparam int ID_W = $clog2(N_SRC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [CNT_W-1:0] SFX_LOAD = CNT_W'(SFX_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    logic [1:0]       state_reg,  state_next;
    logic [N_SRC-1:0] pend_reg,   pend_next;
    logic [N_SRC-1:0] play_reg,   play_next;
    logic [ID_W-1:0]  cur_id_reg, cur_id_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;

    logic [N_SRC-1:0] cur_onehot;
    logic [N_SRC-1:0] eff_req;
    logic [N_SRC-1:0] cand;
    logic [N_SRC:0]   seen;
    logic [N_SRC-1:0] win_onehot;
    logic [ID_W-1:0]  win_id;
    logic             cand_any;
    logic             grant_ok;

    // Lowest set index wins: a bit wins only if no lower bit is set.
    assign seen[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_prio
            assign cur_onehot[gi] = (cur_id_reg == ID_W'(gi));
            assign win_onehot[gi] = cand[gi] & ~seen[gi];
            assign seen[gi+1]     = seen[gi] | cand[gi];
        end
    endgenerate

    assign cand_any = seen[N_SRC];

    always_comb begin
        win_id = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_onehot[i]) win_id = win_id | ID_W'(i);
        end
    end

    // The source currently on air cannot queue a replay of itself.
    always_comb begin
        eff_req = bus.req;
        if (state_reg == ST_PLAY) eff_req = bus.req & ~cur_onehot;
    end

    assign cand = pend_reg | eff_req;

    always_comb begin
        state_next  = state_reg;
        pend_next   = cand;
        play_next   = '0;
        cur_id_next = cur_id_reg;
        cnt_next    = cnt_reg;
        grant_ok    = 1'b0;

        case (state_reg)
            ST_IDLE: grant_ok = 1'b1;
            ST_PLAY: begin
                if (cand_any && (win_id < cur_id_reg)) begin
                    grant_ok = 1'b1;
                end else if (cnt_reg == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = ST_GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                        grant_ok   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    grant_ok   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A pre-empted source is simply overwritten; its pend bit is already clear.
        if (grant_ok && cand_any) begin
            state_next  = ST_PLAY;
            cur_id_next = win_id;
            play_next   = win_onehot;
            cnt_next    = SFX_LOAD;
            pend_next   = cand & ~win_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            pend_reg   <= '0;
            play_reg   <= '0;
            cur_id_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            pend_reg   <= pend_next;
            play_reg   <= play_next;
            cur_id_reg <= cur_id_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.play   = play_reg;
    assign bus.busy   = (state_reg == ST_PLAY);
    assign bus.cur_id = cur_id_reg;

    // Outside PLAY the amplifier is held in shutdown.
    assign bus.pmod_1 = bus.busy ? bus.p1_in[cur_id_reg] : 1'b0;
    assign bus.pmod_2 = bus.busy ? bus.p2_in[cur_id_reg] : 1'b0;
    assign bus.pmod_4 = bus.busy ? bus.p4_in[cur_id_reg] : 1'b0;
endmodule

// File: tb/tb_sfx_arbiter.sv
// Bench for sfx_arbiter with N_SRC=2, SFX_CYCLES=8, GAP_CYCLES=2: directed
// scenarios with literal expectations, then random traffic against a clip-level model.
module tb_sfx_arbiter;
    localparam int N   = 2;
    localparam int SFX = 8;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sfx_arbiter_if #(.N_SRC(N)) bus ();

    sfx_arbiter #(
        .N_SRC(N), .SFX_CYCLES(SFX), .GAP_CYCLES(GAP), .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clip-level model: who is on air, how many busy / gap cycles remain, what is queued.
    logic [1:0] m_pend;
    logic [1:0] m_play;
    bit         m_playing;
    int         m_id;
    int         m_left;
    int         m_gap;

    task automatic model_edge(input logic [1:0] r, input logic rs);
        logic [1:0] eff;
        logic [1:0] cand;
        int         w;
        bit         grant_ok;
        if (!rs) begin
            m_pend = 0; m_play = 0; m_playing = 0; m_id = 0; m_left = 0; m_gap = 0;
            return;
        end
        eff = r;
        if (m_playing) eff[m_id] = 1'b0;
        cand = m_pend | eff;
        w = -1;
        for (int i = 0; i < N; i++) if (cand[i] && w < 0) w = i;
        grant_ok = 0;
        if (m_playing) begin
            if (w >= 0 && w < m_id) grant_ok = 1;
            else if (m_left == 1) begin
                m_playing = 0;
                if (GAP > 0) m_gap = GAP; else grant_ok = 1;
            end else m_left--;
        end else if (m_gap > 0) begin
            if (m_gap == 1) begin m_gap = 0; grant_ok = 1; end
            else m_gap--;
        end else grant_ok = 1;
        m_play = 0;
        if (grant_ok && w >= 0) begin
            m_playing = 1; m_id = w; m_left = SFX; m_gap = 0;
            m_play[w] = 1'b1;
            cand[w] = 1'b0;
        end
        m_pend = cand;
    endtask

    // One clock: present req, let the edge happen, then settle to the falling edge.
    task automatic tick(input logic [1:0] r);
        bus.req = r;
        @(posedge clk);
        model_edge(r, rst);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.p1_in = 2'b11; bus.p2_in = 2'b11; bus.p4_in = 2'b11;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(2'b11);
            checks++; if (bus.play !== 2'b00) begin errors++; $display("FAIL reset_play c=%0d got=%b want=00", c, bus.play); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy c=%0d got=%b want=0", c, bus.busy); end
            checks++; if ({bus.pmod_1, bus.pmod_2, bus.pmod_4} !== 3'b000) begin errors++; $display("FAIL reset_pmod c=%0d got=%b want=000", c, {bus.pmod_1, bus.pmod_2, bus.pmod_4}); end
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(2'b00);
            checks++; if (bus.play !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_pend c=%0d play=%b busy=%b want 00/0", c, bus.play, bus.busy); end
        end
    endtask

    task automatic test_single();
        logic [1:0] pe;
        logic       be;
        logic       pm;
        for (int c = 1; c <= 11; c++) begin
            bus.p1_in = 2'($urandom);
            tick(c == 1 ? 2'b10 : 2'b00);
            pe = (c == 1) ? 2'b10 : 2'b00;
            be = (c <= 8);
            pm = be ? bus.p1_in[1] : 1'b0;
            checks++; if (bus.play !== pe) begin errors++; $display("FAIL single_play c=%0d got=%b want=%b", c, bus.play, pe); end
            checks++; if (bus.busy !== be) begin errors++; $display("FAIL single_busy c=%0d got=%b want=%b", c, bus.busy, be); end
            checks++; if (bus.pmod_1 !== pm) begin errors++; $display("FAIL single_pmod1 c=%0d got=%b want=%b", c, bus.pmod_1, pm); end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] pe;
        logic       be;
        for (int c = 1; c <= 21; c++) begin
            tick(c == 1 ? 2'b11 : 2'b00);
            pe = (c == 1) ? 2'b01 : (c == 11) ? 2'b10 : 2'b00;
            be = (c <= 8) || (c >= 11 && c <= 18);
            checks++; if (bus.play !== pe) begin errors++; $display("FAIL simul_play c=%0d got=%b want=%b", c, bus.play, pe); end
            checks++; if (bus.busy !== be) begin errors++; $display("FAIL simul_busy c=%0d got=%b want=%b", c, bus.busy, be); end
            if (be) begin
                checks++; if (bus.cur_id !== ((c <= 8) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL simul_id c=%0d got=%0d", c, bus.cur_id); end
            end
        end
    endtask

    task automatic test_preempt();
        logic [1:0] pe;
        logic       be;
        for (int c = 1; c <= 20; c++) begin
            tick(c == 1 ? 2'b10 : (c == 5) ? 2'b01 : 2'b00);
            pe = (c == 1) ? 2'b10 : (c == 5) ? 2'b01 : 2'b00;
            be = (c <= 12);
            checks++; if (bus.play !== pe) begin errors++; $display("FAIL preempt_play c=%0d got=%b want=%b", c, bus.play, pe); end
            checks++; if (bus.busy !== be) begin errors++; $display("FAIL preempt_busy c=%0d got=%b want=%b", c, bus.busy, be); end
            if (be) begin
                checks++; if (bus.cur_id !== ((c < 5) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL preempt_id c=%0d got=%0d", c, bus.cur_id); end
            end
        end
    endtask

    task automatic test_repeat();
        logic [1:0] pe;
        logic       be;
        for (int c = 1; c <= 14; c++) begin
            tick((c == 1 || c == 3) ? 2'b01 : 2'b00);
            pe = (c == 1) ? 2'b01 : 2'b00;
            be = (c <= 8);
            checks++; if (bus.play !== pe) begin errors++; $display("FAIL repeat_play c=%0d got=%b want=%b", c, bus.play, pe); end
            checks++; if (bus.busy !== be) begin errors++; $display("FAIL repeat_busy c=%0d got=%b want=%b", c, bus.busy, be); end
        end
    endtask

    task automatic test_pins();
        logic [1:0] pv;
        logic [2:0] want;
        for (int c = 1; c <= 12; c++) begin
            pv = (c > 8) ? 2'b11 : (c % 2 == 1) ? 2'b10 : 2'b01;
            bus.p1_in = pv; bus.p2_in = pv; bus.p4_in = pv;
            tick(c == 1 ? 2'b01 : 2'b00);
            want = (c <= 8) ? {3{pv[0]}} : 3'b000;
            checks++; if ({bus.pmod_1, bus.pmod_2, bus.pmod_4} !== want) begin errors++; $display("FAIL pins c=%0d got=%b want=%b", c, {bus.pmod_1, bus.pmod_2, bus.pmod_4}, want); end
        end
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic [2:0] want;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) != 0);
            r = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            bus.p1_in = 2'($urandom); bus.p2_in = 2'($urandom); bus.p4_in = 2'($urandom);
            tick(r);
            checks++; if (bus.play !== m_play) begin errors++; $display("FAIL rand_play c=%0d got=%b want=%b", c, bus.play, m_play); end
            checks++; if (bus.busy !== m_playing) begin errors++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, bus.busy, m_playing); end
            if (m_playing) begin
                checks++; if (bus.cur_id !== 1'(m_id)) begin errors++; $display("FAIL rand_id c=%0d got=%0d want=%0d", c, bus.cur_id, m_id); end
            end
            want = m_playing ? {bus.p1_in[m_id], bus.p2_in[m_id], bus.p4_in[m_id]} : 3'b000;
            checks++; if ({bus.pmod_1, bus.pmod_2, bus.pmod_4} !== want) begin errors++; $display("FAIL rand_pmod c=%0d got=%b want=%b", c, {bus.pmod_1, bus.pmod_2, bus.pmod_4}, want); end
        end
        rst = 1'b1;
    endtask

    task automatic settle();
        for (int c = 0; c < 12; c++) tick(2'b00);
    endtask

    initial begin
        bus.req = 2'b00; bus.p1_in = 2'b00; bus.p2_in = 2'b00; bus.p4_in = 2'b00;
        m_pend = 0; m_play = 0; m_playing = 0; m_id = 0; m_left = 0; m_gap = 0;
        @(negedge clk);
        test_reset();
        test_single();       settle();
        test_simultaneous(); settle();
        test_preempt();      settle();
        test_repeat();       settle();
        test_pins();         settle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
